// File: rtl/spi_master_if.sv
// Host-side bundle for spi_master: SPI pins, byte-stream TX handshake and RX strobe.
// The master modport belongs to the SPI master; the slave modport belongs to whatever drives it.
interface spi_master_if;
  logic       spiDataOut;
  logic       spiClkOut;
  logic       spiSelectOut;
  logic       spiDataIn;
  logic [7:0] txDataIn;
  logic       txDataValid;
  logic       txDataLast;
  logic       txDataReady;
  logic       endPacket;
  logic [7:0] rxDataOut;
  logic       rxDataRdy;
  logic       busy;

  modport master (
    output spiDataOut, spiClkOut, spiSelectOut, txDataReady, rxDataOut, rxDataRdy, busy,
    input  spiDataIn, txDataIn, txDataValid, txDataLast, endPacket
  );

  modport slave (
    input  spiDataOut, spiClkOut, spiSelectOut, txDataReady, rxDataOut, rxDataRdy, busy,
    output spiDataIn, txDataIn, txDataValid, txDataLast, endPacket
  );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI master: mode 0, MSB first, active-high select, packets framed by select.
// Define SPI_MASTER_LOOPBACK_EN to add input loopbackEn (rx path samples MOSI instead of MISO).
module spi_master #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic         loopbackEn,
`endif
  spi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, HOLD, TAIL, GAP} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       last_q, last_d;
  logic       sck_q, sck_d;
  logic       sel_q, sel_d;
  logic       mosi_q, mosi_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  logic accept;
  logic rx_sample;
  logic timer_done;

  assign accept     = bus.txDataValid && ready_q;
  assign timer_done = (timer_q == DIV_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_sample = loopbackEn ? mosi_q : bus.spiDataIn;
`else
  assign rx_sample = bus.spiDataIn;
`endif

  // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 8'd1;
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    sck_d      = sck_q;
    sel_d      = sel_q;
    mosi_d     = mosi_q;
    rx_rdy_d   = 1'b0;

    unique case (state_q)
      IDLE, HOLD: begin
        timer_d = '0;
        if (accept) begin
          sel_d      = 1'b1;
          mosi_d     = bus.txDataIn[7];
          tx_shift_d = bus.txDataIn[6:0];
          last_d     = bus.txDataLast;
          bitcnt_d   = '0;
          state_d    = SETUP;
        end else if (state_q == HOLD && bus.endPacket) begin
          state_d = TAIL;
        end
      end
      SETUP, LO: begin
        if (timer_done) begin
          timer_d = '0;
          sck_d   = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (timer_done) begin
          timer_d    = '0;
          sck_d      = 1'b0;
          rx_shift_d = {rx_shift_q[5:0], rx_sample};
          if (bitcnt_q != 3'd7) begin
            // MOSI only moves on the SCK falling edge, so it is stable for the next HI phase.
            mosi_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            bitcnt_d   = bitcnt_q + 3'd1;
            state_d    = LO;
          end else begin
            rx_data_d = {rx_shift_q, rx_sample};
            rx_rdy_d  = 1'b1;
            bitcnt_d  = '0;
            state_d   = last_q ? TAIL : HOLD;
          end
        end
      end
      TAIL: begin
        if (timer_done) begin
          timer_d = '0;
          sel_d   = 1'b0;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered from the next state so they line up with state_q.
    ready_d = (state_d == IDLE) || (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      sel_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_rdy_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      sel_q      <= sel_d;
      mosi_q     <= mosi_d;
      rx_rdy_q   <= rx_rdy_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.spiDataOut   = mosi_q;
  assign bus.spiClkOut    = sck_q;
  assign bus.spiSelectOut = sel_q;
  assign bus.txDataReady  = ready_q;
  assign bus.rxDataOut    = rx_data_q;
  assign bus.rxDataRdy    = rx_rdy_q;
  assign bus.busy         = busy_q;
endmodule
